// File: rtl/updown_pkg.sv
// rtl/updown_pkg.sv - shared types and mode encodings for the up/down sequence controller
//
// Contents:
//   state_e     : controller states IDLE, LOAD, RUN
//   mode_e      : sequencing modes ONESHOT, RELOAD, PINGPONG
//   MODE_*      : raw 2-bit mode encodings as seen on the mode input
//   decode_mode : maps a raw mode value to mode_e (reserved 11 folds to ONESHOT)
package updown_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_e;

    localparam logic [1:0] MODE_ONESHOT  = 2'b00;
    localparam logic [1:0] MODE_RELOAD   = 2'b01;
    localparam logic [1:0] MODE_PINGPONG = 2'b10;
    localparam logic [1:0] MODE_RSVD     = 2'b11;

    typedef enum logic [1:0] {
        ONESHOT  = MODE_ONESHOT,
        RELOAD   = MODE_RELOAD,
        PINGPONG = MODE_PINGPONG
    } mode_e;

    // Decoding at capture time means the reserved code never reaches the FSM.
    function automatic mode_e decode_mode(input logic [1:0] raw);
        case (raw)
            MODE_RELOAD:   decode_mode = RELOAD;
            MODE_PINGPONG: decode_mode = PINGPONG;
            default:       decode_mode = ONESHOT;
        endcase
    endfunction

endpackage

// File: rtl/updown_core.sv
// rtl/updown_core.sv - loadable wrapping up/down counter
//
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous active-low reset, clears count
//   enable   : step count by one this edge
//   load     : load data_in this edge (wins over enable)
//   upordown : step direction, 1 = up, 0 = down
//   data_in  : value to load
//   count    : current counter value
module updown_core
    import updown_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             load,
    input  logic             upordown,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    // Plain WIDTH-bit arithmetic gives the modulo 2^WIDTH wrap in both directions.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= data_in;
        end else if (enable) begin
            count_q <= upordown ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/updown_seq_ctrl.sv
// rtl/updown_seq_ctrl.sv - sequencing FSM driving an up/down counter between two values
//
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-low reset
//   start     : request a sequence (only honoured in IDLE)
//   stop      : abort any sequence (honoured in every state, beats start)
//   dir_in    : initial direction, 1 = up
//   mode      : 00 ONESHOT, 01 RELOAD, 10 PINGPONG, 11 treated as ONESHOT
//   start_val : origin value
//   end_val   : terminal value
//   count     : live counter value
//   busy      : high in LOAD and RUN
//   done      : one-cycle pulse after each terminal hit
//   dir_out   : current step direction
module updown_seq_ctrl
    import updown_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             dir_in,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] start_val,
    input  logic [WIDTH-1:0] end_val,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             dir_out
);

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] org_q, org_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic             done_q, done_d;

    logic             core_en;
    logic             core_load;
    logic [WIDTH-1:0] count_w;
    logic             hit;

    assign hit = (count_w == tgt_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            mode_q  <= ONESHOT;
            dir_q   <= 1'b0;
            org_q   <= '0;
            tgt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            org_q   <= org_d;
            tgt_q   <= tgt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        dir_d     = dir_q;
        org_d     = org_q;
        tgt_d     = tgt_q;
        done_d    = 1'b0;
        core_en   = 1'b0;
        core_load = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    dir_d   = dir_in;
                    mode_d  = decode_mode(mode);
                    org_d   = start_val;
                    tgt_d   = end_val;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (stop) begin
                    state_d = IDLE;
                end else begin
                    core_load = 1'b1;
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (hit) begin
                    // Terminal edge: no step; the mode decides what happens instead.
                    done_d = 1'b1;
                    case (mode_q)
                        RELOAD: core_load = 1'b1;
                        PINGPONG: begin
                            org_d = tgt_q;
                            tgt_d = org_q;
                            dir_d = ~dir_q;
                        end
                        default: state_d = IDLE;
                    endcase
                end else begin
                    core_en = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    updown_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .enable  (core_en),
        .load    (core_load),
        .upordown(dir_q),
        .data_in (org_q),
        .count   (count_w)
    );

    assign count   = count_w;
    assign busy    = (state_q == LOAD) || (state_q == RUN);
    assign done    = done_q;
    assign dir_out = dir_q;

endmodule

// File: tb/tb_updown_seq_ctrl.sv
// tb/tb_updown_seq_ctrl.sv - self-checking bench for updown_seq_ctrl
module tb_updown_seq_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         stop;
    logic         dir_in;
    logic [1:0]   mode;
    logic [W-1:0] start_val;
    logic [W-1:0] end_val;
    logic [W-1:0] count;
    logic         busy;
    logic         done;
    logic         dir_out;

    int           n_checks = 0;
    int           n_pass   = 0;
    logic [W-1:0] m_count;

    always #5 clk = ~clk;

    updown_seq_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .dir_in   (dir_in),
        .mode     (mode),
        .start_val(start_val),
        .end_val  (end_val),
        .count    (count),
        .busy     (busy),
        .done     (done),
        .dir_out  (dir_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        dir_in    = 1'($urandom_range(0, 1));
        mode      = 2'($urandom_range(0, 3));
        start_val = W'($urandom);
        end_val   = W'($urandom);
    endtask

    // Edge k=0 captures, k=1 loads the origin, k>=2 are RUN edges.
    // stop_k / rst_k select the edge at which stop or an async reset hits (0 = never).
    task automatic run_seq(input logic d, input logic [1:0] m, input logic [W-1:0] s,
                           input logic [W-1:0] e, input int n_run, input int stop_k,
                           input int rst_k, input logic junk);
        logic [W-1:0] org;
        logic [W-1:0] tgt;
        logic         dr;
        logic         act;
        logic         stp;
        logic         exp_done;
        dir_in = d; mode = m; start_val = s; end_val = e;
        start = 1'b1; stop = 1'b0;
        tick();
        start = 1'b0;
        if (junk) scramble();
        check("cap_busy", 32'(busy), 32'd1);
        check("cap_count", 32'(count), 32'(m_count));
        check("cap_dir", 32'(dir_out), 32'(d));
        check("cap_done", 32'(done), 32'd0);
        org = s; tgt = e; dr = d; act = 1'b1;
        for (int k = 1; act && k <= n_run + 2; k++) begin
            if (k == rst_k) begin
                #3 rst = 1'b0;
                #1;
                check("rst_count", 32'(count), 32'd0);
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_done", 32'(done), 32'd0);
                check("rst_dir", 32'(dir_out), 32'd0);
                @(posedge clk);
                #2;
                check("rst_hold_count", 32'(count), 32'd0);
                rst = 1'b1;
                m_count = '0;
                act = 1'b0;
            end else begin
                stp  = (k == stop_k) || (k == n_run + 2);
                stop = stp;
                if (junk) begin
                    start = 1'($urandom_range(0, 1));
                    scramble();
                end
                if (stp) start = 1'b1;
                tick();
                start = 1'b0;
                stop  = 1'b0;
                exp_done = 1'b0;
                if (stp) begin
                    act = 1'b0;
                end else if (k == 1) begin
                    m_count = org;
                end else if (m_count == tgt) begin
                    exp_done = 1'b1;
                    if (m == 2'b01) begin
                        m_count = org;
                    end else if (m == 2'b10) begin
                        {org, tgt} = {tgt, org};
                        dr = ~dr;
                    end else begin
                        act = 1'b0;
                    end
                end else begin
                    m_count = dr ? W'(m_count + 1) : W'(m_count - 1);
                end
                check("run_count", 32'(count), 32'(m_count));
                check("run_busy", 32'(busy), 32'(act));
                check("run_done", 32'(done), 32'(exp_done));
                check("run_dir", 32'(dir_out), 32'(dr));
            end
        end
        // start together with stop in IDLE must not launch a sequence
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);
        check("idle_count", 32'(count), 32'(m_count));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; start = 1'b0; stop = 1'b0; dir_in = 1'b0;
        mode = 2'b00; start_val = '0; end_val = '0;
        m_count = '0;
        #1;
        check("reset_count", 32'(count), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_dir", 32'(dir_out), 32'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;

        run_seq(1'b1, 2'b00, 4'd3, 4'd7,  10, 0, 0, 1'b1);
        run_seq(1'b0, 2'b00, 4'd2, 4'd14, 10, 0, 0, 1'b1);
        run_seq(1'b1, 2'b01, 4'd1, 4'd3,   9, 0, 0, 1'b0);
        run_seq(1'b1, 2'b10, 4'd5, 4'd8,  14, 0, 0, 1'b1);
        run_seq(1'b1, 2'b00, 4'd3, 4'd9,  10, 5, 0, 1'b0);
        run_seq(1'b0, 2'b01, 4'd6, 4'd2,  10, 1, 0, 1'b0);
        run_seq(1'b1, 2'b00, 4'd5, 4'd5,   4, 0, 0, 1'b0);
        run_seq(1'b0, 2'b10, 4'd9, 4'd9,   6, 0, 0, 1'b0);
        run_seq(1'b1, 2'b11, 4'd14, 4'd1, 10, 0, 0, 1'b1);
        run_seq(1'b1, 2'b10, 4'd4, 4'd9,  10, 0, 4, 1'b0);
        run_seq(1'b1, 2'b00, 4'd3, 4'd7,  10, 0, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            int nr;
            int sk;
            int rk;
            nr = $urandom_range(0, 24);
            sk = ($urandom_range(0, 3) == 0) ? $urandom_range(1, nr + 2) : 0;
            rk = ($urandom_range(0, 7) == 0) ? $urandom_range(1, nr + 2) : 0;
            run_seq(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    W'($urandom), W'($urandom), nr, sk, rk, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
